// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: drives a valid/ready data-memory port, aligns load data, pulses writeback.
// Define MEM_WB_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of issuing them.
//
// state   | meaning
// IDLE    | accept from execute; non-memory ops write back next cycle
// REQ     | request presented, held until dmem_req_ready
// WAIT    | request accepted, waiting for response or timeout
module mem_wb_stage #(
    parameter int XLEN     = 32,
    parameter int REG_BITS = 5,
    parameter int MAX_WAIT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_in,
    input  logic                mem_write_in,
    input  logic                mem_read_in,
    input  logic [XLEN-1:0]     mem_addr_in,
    input  logic [XLEN-1:0]     mem_data_in,
    input  logic [7:0]          mem_mask_in,
    input  logic [2:0]          funct3_in,
    input  logic [REG_BITS-1:0] rd_in,
    input  logic                wb_en_in,
    input  logic [XLEN-1:0]     alu_result_in,
    output logic                stall_out,
    output logic                dmem_req_valid,
    input  logic                dmem_req_ready,
    output logic                dmem_req_write,
    output logic [XLEN-1:0]     dmem_req_addr,
    output logic [XLEN-1:0]     dmem_req_wdata,
    output logic [3:0]          dmem_req_strb,
    input  logic                dmem_resp_valid,
    input  logic [XLEN-1:0]     dmem_resp_rdata,
    output logic                wb_valid_out,
    output logic [REG_BITS-1:0] wb_rd_out,
    output logic [XLEN-1:0]     wb_data_out,
`ifdef MEM_WB_MISALIGN_TRAP_EN
    output logic                timeout_out,
    output logic                misalign_trap_out
`else
    output logic                timeout_out
`endif
);

    localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

    state_t                state_q, state_d;
    logic [1:0]            off_q;
    logic [2:0]            funct3_q;
    logic [REG_BITS-1:0]   rd_q;
    logic [CW-1:0]         cnt_q, cnt_inc;
    logic                  mem_op, misalign, accept, timeout_hit;
    logic [XLEN-1:0]       shifted, load_val;
    logic                  unused_mask;

    // Execute only ever produces masks up to 4'hF; the upper bits carry nothing here.
    assign unused_mask = ^mem_mask_in[7:4];

    assign mem_op = valid_in && (mem_write_in || mem_read_in);
`ifdef MEM_WB_MISALIGN_TRAP_EN
    assign misalign = ((funct3_in[1:0] == 2'd1) && mem_addr_in[0]) ||
                      ((funct3_in[1:0] == 2'd2) && (mem_addr_in[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif
    assign accept      = mem_op && !misalign;
    assign cnt_inc     = cnt_q + CW'(1);
    assign timeout_hit = (MAX_WAIT != 0) && (cnt_inc == MAX_CNT);

    assign stall_out      = (state_q != ST_IDLE);
    assign dmem_req_valid = (state_q == ST_REQ);

    assign shifted = dmem_resp_rdata >> {off_q, 3'b000};

    always_comb begin
        load_val = '0;
        case (funct3_q)
            3'd0:    load_val = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'd4:    load_val = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'd1:    load_val = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'd5:    load_val = {{(XLEN-16){1'b0}}, shifted[15:0]};
            3'd2:    load_val = shifted;
            default: load_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_REQ;
            ST_REQ:  if (dmem_req_ready) state_d = ST_WAIT;
            ST_WAIT: if (dmem_resp_valid || timeout_hit) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dmem_req_write <= 1'b0;
            dmem_req_addr  <= '0;
            dmem_req_wdata <= '0;
            dmem_req_strb  <= '0;
            off_q          <= '0;
            funct3_q       <= '0;
            rd_q           <= '0;
            cnt_q          <= '0;
            wb_valid_out   <= 1'b0;
            wb_rd_out      <= '0;
            wb_data_out    <= '0;
            timeout_out    <= 1'b0;
        end else begin
            wb_valid_out <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        // A combined read+write request is issued as a store.
                        dmem_req_write <= mem_write_in;
                        dmem_req_addr  <= {mem_addr_in[XLEN-1:2], 2'b00};
                        dmem_req_wdata <= mem_data_in << {mem_addr_in[1:0], 3'b000};
                        dmem_req_strb  <= mem_mask_in[3:0] << mem_addr_in[1:0];
                        off_q          <= mem_addr_in[1:0];
                        funct3_q       <= funct3_in;
                        rd_q           <= rd_in;
                        cnt_q          <= '0;
                    end else if (valid_in && !mem_op) begin
                        wb_valid_out <= wb_en_in && (rd_in != '0);
                        wb_rd_out    <= rd_in;
                        wb_data_out  <= alu_result_in;
                    end
                end
                ST_REQ: cnt_q <= '0;
                ST_WAIT: begin
                    cnt_q <= cnt_inc;
                    if (dmem_resp_valid) begin
                        if (!dmem_req_write) begin
                            wb_valid_out <= (rd_q != '0);
                            wb_rd_out    <= rd_q;
                            wb_data_out  <= load_val;
                        end
                    end else if (timeout_hit) begin
                        timeout_out <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_WB_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) misalign_trap_out <= 1'b0;
        else        misalign_trap_out <= (state_q == ST_IDLE) && mem_op && misalign;
    end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: table of ALU/load vectors plus hand sequences for
// stalled stores, timeout, reset mid-access and (optionally) the misalign trap.
module tb_mem_wb_stage;
    localparam int XLEN     = 32;
    localparam int REG_BITS = 5;
    localparam int MAX_WAIT = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic                valid_in, mem_write_in, mem_read_in;
    logic [XLEN-1:0]     mem_addr_in, mem_data_in, alu_result_in;
    logic [7:0]          mem_mask_in;
    logic [2:0]          funct3_in;
    logic [REG_BITS-1:0] rd_in;
    logic                wb_en_in;
    logic                stall_out, dmem_req_valid, dmem_req_ready, dmem_req_write;
    logic [XLEN-1:0]     dmem_req_addr, dmem_req_wdata, dmem_resp_rdata, wb_data_out;
    logic [3:0]          dmem_req_strb;
    logic                dmem_resp_valid, wb_valid_out, timeout_out;
    logic [REG_BITS-1:0] wb_rd_out;
`ifdef MEM_WB_MISALIGN_TRAP_EN
    logic                misalign_trap_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mem_wb_stage #(.XLEN(XLEN), .REG_BITS(REG_BITS), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .valid_in(valid_in), .mem_write_in(mem_write_in), .mem_read_in(mem_read_in),
        .mem_addr_in(mem_addr_in), .mem_data_in(mem_data_in), .mem_mask_in(mem_mask_in),
        .funct3_in(funct3_in), .rd_in(rd_in), .wb_en_in(wb_en_in),
        .alu_result_in(alu_result_in), .stall_out(stall_out),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_write(dmem_req_write), .dmem_req_addr(dmem_req_addr),
        .dmem_req_wdata(dmem_req_wdata), .dmem_req_strb(dmem_req_strb),
        .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
        .wb_valid_out(wb_valid_out), .wb_rd_out(wb_rd_out), .wb_data_out(wb_data_out),
`ifdef MEM_WB_MISALIGN_TRAP_EN
        .timeout_out(timeout_out), .misalign_trap_out(misalign_trap_out)
`else
        .timeout_out(timeout_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_load;
        logic        vld;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        wb_en;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        exp_v;
        logic [31:0] exp_d;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        valid_in = 0; mem_write_in = 0; mem_read_in = 0;
        mem_addr_in = '0; mem_data_in = '0; mem_mask_in = '0; funct3_in = '0;
        rd_in = '0; wb_en_in = 0; alu_result_in = '0;
        dmem_req_ready = 0; dmem_resp_valid = 0; dmem_resp_rdata = '0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_stall"},     stall_out, 0);
        check({tag, "_req_valid"}, dmem_req_valid, 0);
        check({tag, "_req_write"}, dmem_req_write, 0);
        check({tag, "_req_addr"},  dmem_req_addr, 0);
        check({tag, "_req_wdata"}, dmem_req_wdata, 0);
        check({tag, "_req_strb"},  dmem_req_strb, 0);
        check({tag, "_wb_valid"},  wb_valid_out, 0);
        check({tag, "_wb_rd"},     wb_rd_out, 0);
        check({tag, "_wb_data"},   wb_data_out, 0);
        check({tag, "_timeout"},   timeout_out, 0);
`ifdef MEM_WB_MISALIGN_TRAP_EN
        check({tag, "_trap"},      misalign_trap_out, 0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //             load vld addr          f3    rd  en alu             rdata           ev exp_d
        vecs[0]  = '{1'b0, 1'b1, 32'h0,   3'd0, 5'd5,  1'b1, 32'h1234,      32'h0,          1'b1, 32'h1234};
        vecs[1]  = '{1'b0, 1'b1, 32'h0,   3'd0, 5'd0,  1'b1, 32'hCAFE,      32'h0,          1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 32'h0,   3'd0, 5'd7,  1'b0, 32'h55,        32'h0,          1'b0, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,   3'd0, 5'd9,  1'b1, 32'h77,        32'h0,          1'b0, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 32'h0,   3'd0, 5'd31, 1'b1, 32'hFFFF_FFFF, 32'h0,          1'b1, 32'hFFFF_FFFF};
        vecs[5]  = '{1'b1, 1'b1, 32'h103, 3'd0, 5'd3,  1'b1, 32'h0, 32'h80FF_0000, 1'b1, 32'hFFFF_FF80};
        vecs[6]  = '{1'b1, 1'b1, 32'h101, 3'd4, 5'd4,  1'b1, 32'h0, 32'h1234_85FF, 1'b1, 32'h0000_0085};
        vecs[7]  = '{1'b1, 1'b1, 32'h102, 3'd1, 5'd6,  1'b1, 32'h0, 32'h8001_7FFF, 1'b1, 32'hFFFF_8001};
        vecs[8]  = '{1'b1, 1'b1, 32'h200, 3'd5, 5'd8,  1'b1, 32'h0, 32'hBEEF_9234, 1'b1, 32'h0000_9234};
        vecs[9]  = '{1'b1, 1'b1, 32'h300, 3'd2, 5'd10, 1'b1, 32'h0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
        vecs[10] = '{1'b1, 1'b1, 32'h304, 3'd3, 5'd11, 1'b1, 32'h0, 32'hFFFF_FFFF, 1'b1, 32'h0};
        vecs[11] = '{1'b1, 1'b1, 32'h202, 3'd5, 5'd0,  1'b1, 32'h0, 32'hBEEF_1234, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 1'b1, 32'h100, 3'd0, 5'd12, 1'b1, 32'h0, 32'h0000_007F, 1'b1, 32'h0000_007F};

        reset = 0;
        idle_inputs();
        repeat (3) tick();
        check_zero_outputs("rst");
        reset = 1;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            v = vecs[i];
            valid_in = v.vld; mem_read_in = v.is_load; mem_write_in = 0;
            mem_addr_in = v.addr; funct3_in = v.f3; rd_in = v.rd; wb_en_in = v.wb_en;
            alu_result_in = v.alu; mem_mask_in = 8'h1; dmem_req_ready = 1;
            tick();
            if (v.is_load) begin
                check($sformatf("ld_stall[%0d]", i), stall_out, 1);
                check($sformatf("ld_req_valid[%0d]", i), dmem_req_valid, 1);
                check($sformatf("ld_req_addr[%0d]", i), dmem_req_addr, v.addr & ~32'h3);
                check($sformatf("ld_req_write[%0d]", i), dmem_req_write, 0);
                check($sformatf("ld_wb_early1[%0d]", i), wb_valid_out, 0);
                valid_in = 0; mem_read_in = 0;
                tick();
                check($sformatf("ld_wait_req_valid[%0d]", i), dmem_req_valid, 0);
                check($sformatf("ld_wait_stall[%0d]", i), stall_out, 1);
                check($sformatf("ld_wb_early2[%0d]", i), wb_valid_out, 0);
                dmem_req_ready = 0; dmem_resp_valid = 1; dmem_resp_rdata = v.rdata;
                tick();
                dmem_resp_valid = 0;
            end
            check($sformatf("wb_valid[%0d]", i), wb_valid_out, v.exp_v);
            check($sformatf("stall_clear[%0d]", i), stall_out, 0);
            if (v.exp_v) begin
                check($sformatf("wb_data[%0d]", i), wb_data_out, v.exp_d);
                check($sformatf("wb_rd[%0d]", i), wb_rd_out, v.rd);
            end
            valid_in = 0; mem_read_in = 0;
            tick();
            check($sformatf("wb_pulse[%0d]", i), wb_valid_out, 0);
        end

        // Store byte with ready held low: fields must stay put while inputs move.
        idle_inputs();
        valid_in = 1; mem_write_in = 1; mem_addr_in = 32'h102; mem_data_in = 32'hAB;
        mem_mask_in = 8'h1; funct3_in = 3'd0; rd_in = 5'd2; wb_en_in = 0;
        tick();
        valid_in = 0; mem_write_in = 0; mem_addr_in = 32'hFFF; mem_data_in = 32'h1234_5678;
        mem_mask_in = 8'hF;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("sb_req_valid[%0d]", k), dmem_req_valid, 1);
            check($sformatf("sb_req_addr[%0d]", k), dmem_req_addr, 32'h100);
            check($sformatf("sb_req_strb[%0d]", k), dmem_req_strb, 4'b0100);
            check($sformatf("sb_req_wdata[%0d]", k), dmem_req_wdata, 32'h00AB_0000);
            check($sformatf("sb_req_write[%0d]", k), dmem_req_write, 1);
            tick();
        end
        dmem_req_ready = 1;
        tick();
        check("sb_wait_req_valid", dmem_req_valid, 0);
        check("sb_wait_stall", stall_out, 1);
        dmem_req_ready = 0; dmem_resp_valid = 1;
        tick();
        dmem_resp_valid = 0;
        check("sb_stall_clear", stall_out, 0);
        check("sb_no_wb", wb_valid_out, 0);

        // Read and write both set: issued as a store, no writeback.
        valid_in = 1; mem_write_in = 1; mem_read_in = 1; mem_addr_in = 32'h204;
        mem_data_in = 32'h1122_3344; mem_mask_in = 8'hF; funct3_in = 3'd2; rd_in = 5'd4;
        wb_en_in = 1; dmem_req_ready = 1;
        tick();
        valid_in = 0; mem_write_in = 0; mem_read_in = 0;
        check("sw_req_write", dmem_req_write, 1);
        check("sw_req_strb", dmem_req_strb, 4'hF);
        check("sw_req_wdata", dmem_req_wdata, 32'h1122_3344);
        check("sw_req_addr", dmem_req_addr, 32'h204);
        tick();
        dmem_req_ready = 0; dmem_resp_valid = 1; dmem_resp_rdata = 32'hFFFF_FFFF;
        tick();
        check("sw_no_wb", wb_valid_out, 0);
        check("sw_stall_clear", stall_out, 0);
        // Stray ack while idle is ignored.
        tick();
        dmem_resp_valid = 0;
        check("stray_ack_wb", wb_valid_out, 0);
        check("stray_ack_stall", stall_out, 0);

`ifdef MEM_WB_MISALIGN_TRAP_EN
        valid_in = 1; mem_read_in = 1; mem_addr_in = 32'h101; funct3_in = 3'd2; rd_in = 5'd5;
        wb_en_in = 1; dmem_req_ready = 1;
        tick();
        valid_in = 0; mem_read_in = 0;
        check("mis_trap", misalign_trap_out, 1);
        check("mis_req_valid", dmem_req_valid, 0);
        check("mis_stall", stall_out, 0);
        check("mis_wb", wb_valid_out, 0);
        tick();
        check("mis_trap_pulse", misalign_trap_out, 0);
        check("mis_req_valid2", dmem_req_valid, 0);
`else
        // Misaligned halfword store issues with truncated strobes.
        valid_in = 1; mem_write_in = 1; mem_addr_in = 32'h103; mem_data_in = 32'hBEEF;
        mem_mask_in = 8'h3; funct3_in = 3'd1; dmem_req_ready = 1;
        tick();
        valid_in = 0; mem_write_in = 0;
        check("sh_mis_req_valid", dmem_req_valid, 1);
        check("sh_mis_strb", dmem_req_strb, 4'b1000);
        check("sh_mis_wdata", dmem_req_wdata, 32'hEF00_0000);
        check("sh_mis_addr", dmem_req_addr, 32'h100);
        tick();
        dmem_req_ready = 0; dmem_resp_valid = 1;
        tick();
        dmem_resp_valid = 0;
        check("sh_mis_stall_clear", stall_out, 0);
`endif

        // Timeout: 8 WAIT cycles with no response.
        idle_inputs();
        valid_in = 1; mem_read_in = 1; mem_addr_in = 32'h400; funct3_in = 3'd2; rd_in = 5'd9;
        wb_en_in = 1; dmem_req_ready = 1;
        tick();
        valid_in = 0; mem_read_in = 0;
        tick();
        dmem_req_ready = 0;
        repeat (7) tick();
        check("to_not_yet", timeout_out, 0);
        check("to_still_stall", stall_out, 1);
        tick();
        check("to_flag", timeout_out, 1);
        check("to_stall_clear", stall_out, 0);
        check("to_no_wb", wb_valid_out, 0);
        valid_in = 1; rd_in = 5'd3; wb_en_in = 1; alu_result_in = 32'hA5;
        tick();
        valid_in = 0;
        check("to_after_wb_valid", wb_valid_out, 1);
        check("to_after_wb_data", wb_data_out, 32'hA5);
        check("to_sticky", timeout_out, 1);

        // Reset while waiting; the late response must be dropped.
        valid_in = 1; mem_read_in = 1; mem_addr_in = 32'h500; funct3_in = 3'd2; rd_in = 5'd7;
        dmem_req_ready = 1;
        tick();
        valid_in = 0; mem_read_in = 0;
        tick();
        dmem_req_ready = 0;
        tick();
        check("rw_in_wait", stall_out, 1);
        #2;
        reset = 0;
        #1;
        check_zero_outputs("rst_mid");
        tick();
        reset = 1;
        dmem_resp_valid = 1; dmem_resp_rdata = 32'h1234_5678;
        tick();
        dmem_resp_valid = 0;
        check("late_resp_wb", wb_valid_out, 0);
        check("late_resp_stall", stall_out, 0);
        check("late_resp_data", wb_data_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline stage directly downstream of the execute/calc stage.
- Consumes the registered memory request (write/read, address, data, byte mask) and the per-instruction state: valid, rd, alu_result, funct3, wb_en.
- Issues the request to a variable-latency data memory over a valid/ready request channel and a response-valid channel.
- Aligns and sign-extends load data, produces a one-cycle register-writeback pulse, and stalls upstream while a memory access is outstanding.

Parameters:
- XLEN, 32, data/address width.
- REG_BITS, 5, register index width.
- MAX_WAIT, 255, response timeout in cycles; 0 disables the timeout.

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-low
- valid_in  input  1  instruction from execute is valid
- mem_write_in  input  1  store request
- mem_read_in  input  1  load request
- mem_addr_in  input  XLEN  byte address
- mem_data_in  input  XLEN  store data (unshifted, low lanes)
- mem_mask_in  input  8  byte mask from execute: 1, 3 or 15
- funct3_in  input  3  load/store width and sign
- rd_in  input  REG_BITS  destination register
- wb_en_in  input  1  instruction writes rd
- alu_result_in  input  XLEN  non-memory writeback value
- stall_out  output  1  upstream must hold its outputs
- dmem_req_valid  output  1  request valid
- dmem_req_ready  input  1  memory accepts request
- dmem_req_write  output  1  1 = store
- dmem_req_addr  output  XLEN  word-aligned address (addr & ~3)
- dmem_req_wdata  output  XLEN  store data shifted to byte lane
- dmem_req_strb  output  4  byte strobes shifted to byte lane
- dmem_resp_valid  input  1  read data / write ack valid
- dmem_resp_rdata  input  XLEN  read word
- wb_valid_out  output  1  writeback strobe
- wb_rd_out  output  REG_BITS  writeback register
- wb_data_out  output  XLEN  writeback value
- timeout_out  output  1  sticky response-timeout flag

Behaviour:
- Reset (asynchronous, reset==0): FSM to IDLE; stall_out, dmem_req_valid, wb_valid_out and timeout_out = 0; wb_rd_out, wb_data_out and all request fields = 0; wait counter = 0.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - valid_in with neither mem_write_in nor mem_read_in: next cycle wb_valid_out = wb_en_in && rd_in != 0, wb_data_out = alu_result_in. Latency 1. No stall.
  - valid_in with mem_write_in or mem_read_in: capture all inputs, go to REQ, assert stall_out from the next cycle.
  - mem_write_in and mem_read_in both set: treat as store.
- REQ:
  - dmem_req_valid = 1, with fields held stable until dmem_req_ready.
  - On the valid && ready cycle, go to WAIT.
  - Lane offset = addr[1:0]: wdata = data << 8*offset; strb = mask[3:0] << offset, truncated to 4 bits.
- WAIT:
  - Counter increments each cycle.
  - On dmem_resp_valid (including the same cycle as entry):
    - Load: wb_valid_out = (rd != 0); wb_data_out = extracted field.
    - Store: no writeback.
    - Return to IDLE; stall_out deasserts in the same cycle the writeback registers update.
  - Minimum load latency, input to wb_valid_out: 3 cycles (IDLE to REQ, REQ to WAIT, WAIT to IDLE), assuming ready and response each arrive on the first possible cycle.
- Load extract: field = rdata >> 8*offset.
  - funct3 0: sign-extend 8 bits. 4: zero-extend 8 bits.
  - funct3 1: sign-extend 16 bits. 5: zero-extend 16 bits.
  - funct3 2: full word.
  - Other funct3: writeback 0.
- Timeout: if MAX_WAIT != 0 and the counter reaches MAX_WAIT in WAIT, set timeout_out (sticky until reset), return to IDLE, no writeback.
- stall_out = (state != IDLE). While stalled, inputs are ignored; upstream holds them.
- wb_valid_out is a single-cycle pulse.
- Write ack without a pending access (IDLE/REQ): ignored.
- Reset mid-access: abandons the transaction immediately; a late response after reset is ignored.

Optional Feature:
- Macro: MEM_WB_MISALIGN_TRAP_EN.
- Defined: adds output misalign_trap_out (1).
  - In IDLE, a valid access is misaligned when halfword (funct3[1:0]==1) && addr[0], or word (funct3[1:0]==2) && addr[1:0] != 0.
  - A misaligned access is not issued: next cycle misalign_trap_out pulses 1, no writeback, no stall.
- Not defined: no port. Misaligned accesses issue with truncated strobes and shifted data as above.

Test Plan:
- ALU op: valid_in=1, wb_en=1, rd=5, alu_result=0x1234 -> next cycle wb_valid_out=1, rd=5, data=0x1234; stall_out stays 0.
- LB sign: read addr 0x103, funct3=0, rdata=0x80FF_0000 after ready at first cycle, response immediately -> wb_data_out=0xFFFF_FF80, wb_valid 3 cycles after input.
- Store byte: addr 0x102, data 0xAB, mask 1, dmem_req_ready low for 4 cycles -> req fields stable throughout; addr=0x100, strb=4'b0100, wdata=0x00AB_0000; no writeback.
- LHU with rd=0: addr 0x202, rdata 0xBEEF_1234 -> no writeback pulse; stall_out clears on response.
- Timeout: MAX_WAIT=8, no response -> timeout_out=1 after 8 WAIT cycles, FSM back to IDLE and accepting new input.
- Reset mid-WAIT: reset low during WAIT, then a response arrives -> all outputs 0, no writeback; with MEM_WB_MISALIGN_TRAP_EN, LW at 0x101 -> misalign_trap_out pulse, no dmem_req_valid.
